pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter / fetch-address generator for the RV32 core.
//  Holds the current fetch PC and issues requests to instruction memory with a valid/ready handshake.
//  Advances sequentially on each accepted request and redirects on branch/JAL/JALR from execute.
//  Traps misaligned targets to a fixed vector. Sits between the execute-stage redirect logic and IMEM.
// PARAMETERS
//  XLEN          32        address/data width
//  RESET_VECTOR  32'h0     PC value loaded by reset
//  TRAP_VECTOR   32'h100   PC loaded on misaligned-target trap
//  IALIGN        4         instruction alignment in bytes (4, or 2 when compressed ISA enabled)
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  reset      in   1     synchronous, active-high
//  stall      in   1     pipeline stall; hold PC, deassert imem_req
//  taken_br   in   1     conditional branch resolved taken
//  is_jal     in   1     JAL in execute
//  is_jalr    in   1     JALR in execute
//  br_pc      in   XLEN  PC of the redirecting instruction
//  imm        in   XLEN  sign-extended immediate
//  rs1_data   in   XLEN  rs1 operand for JALR
//  imem_ready in   1     IMEM accepts request this cycle
//  imem_req   out  1     fetch request valid; address = PC_out
//  PC_out     out  XLEN  current fetch PC
//  pc_plus    out  XLEN  PC_out + IALIGN (combinational, for link register)
//  misaligned out  1     one-cycle pulse: redirect target misaligned
//  mis_addr   out  XLEN  offending target, held until next trap or reset
// BEHAVIOUR
//  Reset (sampled on clk edge): state=BOOT, PC_out=RESET_VECTOR, imem_req=0, misaligned=0, mis_addr=0.
//  Reset overrides every other input in the same cycle, and also aborts any state mid-operation.
//  FSM states:
//   BOOT  -> FETCH after one cycle; imem_req=0.
//   FETCH -> imem_req = !stall.
//   TRAP  -> one cycle, imem_req=0, then FETCH.
//  Redirect target and priority (taken_br > is_jal > is_jalr):
//   branch and JAL target = br_pc + imm.
//   JALR target = (rs1_data + imm) & ~1.
//   All sums are modulo 2^XLEN; wrap-around is silent.
//  Target is misaligned if (target mod IALIGN) != 0, evaluated after the JALR LSB clear.
//  Redirect in FETCH, aligned target:
//   PC_out <= target next edge.
//   Overrides stall and any pending handshake; an unaccepted request is retargeted, not replayed.
//  Redirect in FETCH, misaligned target:
//   PC_out <= TRAP_VECTOR, mis_addr <= target, misaligned=1 for exactly one cycle, state -> TRAP.
//  Redirect during BOOT or TRAP is ignored.
//  No redirect, imem_req && imem_ready: PC_out <= PC_out + IALIGN (wraps to 0).
//  No redirect, stall or !imem_ready: PC_out holds.
//   A request that is not yet accepted keeps imem_req high and the address stable (unless stalled).
//  Latency: a redirect presented on cycle N gives the new PC_out and imem_req on cycle N+1
//   (cycle N+2 for TRAP_VECTOR fetch).
// TESTING
//  1. reset=1 for 2 cycles, then 0 -> PC_out=0, imem_req=0 for BOOT cycle, then imem_req=1 at PC 0.
//  2. imem_ready=1 for 4 cycles -> PC_out 0,4,8,C; with imem_ready low on cycle 2, PC holds at 4 that cycle.
//  3. PC_out=0x10, taken_br=1 with is_jalr=1, br_pc=0x20, imm=0x40 -> PC_out=0x60 (branch wins);
//     is_jalr alone with rs1_data=0x101, imm=0 -> PC_out=0x100.
//  4. is_jal, br_pc=0x20, imm=0x6 (IALIGN=4) -> misaligned pulse 1 cycle, mis_addr=0x26,
//     PC_out=0x100, imem_req low 1 cycle, fetch resumes at 0x100.
//  5. stall=1 and is_jal (target 0x80) same cycle -> PC_out=0x80; while stall stays 1, imem_req=0 and PC holds.
//  6. PC_out=0xFFFFFFFC, accepted fetch -> PC_out=0x0; reset asserted during TRAP -> PC_out=RESET_VECTOR, state BOOT.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32 fetch-PC generator with IMEM handshake, execute redirects and misaligned-target trap
module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h100),
  parameter int IALIGN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            taken_br,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] pc_plus,
  output logic            misaligned,
  output logic [XLEN-1:0] mis_addr
);
  typedef enum logic [1:0] {BOOT, FETCH, TRAP} state_t;
  localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);
  state_t state, state_n;
  logic [XLEN-1:0] pc_n, mis_n, target;
  logic redirect, bad;
  assign target = taken_br || is_jal ? br_pc + imm : (rs1_data + imm) & {{(XLEN-1){1'b1}}, 1'b0};
  assign bad = |(target & (STEP - 1'b1));
  assign redirect = state == FETCH && (taken_br || is_jal || is_jalr);
  assign imem_req = state == FETCH && !stall;
  assign misaligned = state == TRAP;
  assign pc_plus = PC_out + STEP;
  always_comb begin
    state_n = redirect && bad ? TRAP : FETCH;
    pc_n = redirect ? (bad ? TRAP_VECTOR : target) : imem_req && imem_ready ? pc_plus : PC_out;
    mis_n = redirect && bad ? target : mis_addr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      PC_out <= RESET_VECTOR;
      mis_addr <= '0;
    end else begin
      state <= state_n;
      PC_out <= pc_n;
      mis_addr <= mis_n;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
  logic clk = 0, reset = 1, stall = 0, taken_br = 0, is_jal = 0, is_jalr = 0, imem_ready = 0;
  logic [31:0] br_pc = 0, imm = 0, rs1_data = 0;
  logic imem_req, misaligned;
  logic [31:0] PC_out, pc_plus, mis_addr;
  int checks = 0, failures = 0;
  int m_mode;
  logic [31:0] m_pc, m_mis;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .taken_br(taken_br), .is_jal(is_jal), .is_jalr(is_jalr),
    .br_pc(br_pc), .imm(imm), .rs1_data(rs1_data), .imem_ready(imem_ready), .imem_req(imem_req),
    .PC_out(PC_out), .pc_plus(pc_plus), .misaligned(misaligned), .mis_addr(mis_addr)
  );

  always #5 clk = ~clk;

  function automatic void step_model();
    logic [31:0] t;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_mis = 0;
    end else if (m_mode != 1) begin
      m_mode = 1;
    end else if (taken_br || is_jal || is_jalr) begin
      t = (taken_br || is_jal) ? br_pc + imm : (rs1_data + imm) & 32'hFFFF_FFFE;
      if (t % 4 != 0) begin
        m_mode = 2; m_mis = t; m_pc = 32'h100;
      end else m_pc = t;
    end else if (!stall && imem_ready) m_pc = m_pc + 4;
  endfunction

  task automatic cyc();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; taken_br = 0; is_jal = 0; is_jalr = 0; imem_ready = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; imem_ready = 1; is_jal = 1; br_pc = 32'h40;
    cyc(); cyc();
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC_out); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (misaligned !== 1'b0 || mis_addr !== 32'h0) begin failures++; $display("FAIL reset_mis got=%b/%h exp=0/0", misaligned, mis_addr); end
    idle();
    checks++; if (imem_req !== 1'b0 || PC_out !== 32'h0) begin failures++; $display("FAIL boot_cycle got req=%b pc=%h exp req=0 pc=0", imem_req, PC_out); end
    cyc();
    checks++; if (imem_req !== 1'b1 || PC_out !== 32'h0) begin failures++; $display("FAIL first_fetch got req=%b pc=%h exp req=1 pc=0", imem_req, PC_out); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc[4] = '{32'h4, 32'h4, 32'h8, 32'hC};
    logic rdy[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      imem_ready = rdy[i];
      cyc();
      checks++; if (PC_out !== exp_pc[i] || imem_req !== 1'b1) begin failures++; $display("FAIL seq_%0d got pc=%h req=%b exp pc=%h req=1", i, PC_out, imem_req, exp_pc[i]); end
    end
  endtask

  task automatic test_priority();
    imem_ready = 1; cyc();
    checks++; if (PC_out !== 32'h10) begin failures++; $display("FAIL prio_setup got=%h exp=10", PC_out); end
    taken_br = 1; is_jalr = 1; br_pc = 32'h20; imm = 32'h40; rs1_data = 32'h1000;
    cyc();
    checks++; if (PC_out !== 32'h60 || imem_req !== 1'b1) begin failures++; $display("FAIL branch_wins got pc=%h req=%b exp pc=60 req=1", PC_out, imem_req); end
    idle(); is_jalr = 1; rs1_data = 32'h101; imm = 0;
    cyc();
    checks++; if (PC_out !== 32'h100 || misaligned !== 1'b0) begin failures++; $display("FAIL jalr_lsb got pc=%h mis=%b exp pc=100 mis=0", PC_out, misaligned); end
    checks++; if (pc_plus !== 32'h104) begin failures++; $display("FAIL pc_plus got=%h exp=104", pc_plus); end
    idle();
  endtask

  task automatic test_trap();
    is_jal = 1; br_pc = 32'h20; imm = 32'h6;
    cyc();
    checks++; if (misaligned !== 1'b1 || mis_addr !== 32'h26) begin failures++; $display("FAIL trap_pulse got mis=%b addr=%h exp mis=1 addr=26", misaligned, mis_addr); end
    checks++; if (PC_out !== 32'h100 || imem_req !== 1'b0) begin failures++; $display("FAIL trap_pc got pc=%h req=%b exp pc=100 req=0", PC_out, imem_req); end
    br_pc = 32'h200; imm = 0;
    cyc();
    idle();
    checks++; if (misaligned !== 1'b0 || imem_req !== 1'b1 || PC_out !== 32'h100) begin failures++; $display("FAIL trap_resume got mis=%b req=%b pc=%h exp mis=0 req=1 pc=100", misaligned, imem_req, PC_out); end
    checks++; if (mis_addr !== 32'h26) begin failures++; $display("FAIL mis_addr_hold got=%h exp=26", mis_addr); end
  endtask

  task automatic test_stall_redirect();
    stall = 1; is_jal = 1; br_pc = 32'h40; imm = 32'h40;
    cyc();
    is_jal = 0; imem_ready = 1;
    checks++; if (PC_out !== 32'h80 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_jal got pc=%h req=%b exp pc=80 req=0", PC_out, imem_req); end
    cyc(); cyc();
    checks++; if (PC_out !== 32'h80 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold got pc=%h req=%b exp pc=80 req=0", PC_out, imem_req); end
    idle();
  endtask

  task automatic test_wrap_and_reset();
    is_jal = 1; br_pc = 0; imm = 32'hFFFF_FFFC;
    cyc();
    idle(); imem_ready = 1;
    checks++; if (PC_out !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin failures++; $display("FAIL wrap_setup got pc=%h plus=%h exp pc=fffffffc plus=0", PC_out, pc_plus); end
    cyc();
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", PC_out); end
    idle(); is_jal = 1; br_pc = 32'h1; imm = 0;
    cyc();
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL trap_before_reset got=%b exp=1", misaligned); end
    reset = 1; br_pc = 32'h40;
    cyc();
    idle();
    checks++; if (PC_out !== 32'h0 || imem_req !== 1'b0 || misaligned !== 1'b0 || mis_addr !== 32'h0) begin failures++; $display("FAIL reset_in_trap got pc=%h req=%b mis=%b addr=%h exp 0/0/0/0", PC_out, imem_req, misaligned, mis_addr); end
    cyc();
    checks++; if (imem_req !== 1'b1 || PC_out !== 32'h0) begin failures++; $display("FAIL refetch got req=%b pc=%h exp req=1 pc=0", imem_req, PC_out); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 59) == 0;
      stall = $urandom_range(0, 3) == 0;
      imem_ready = $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 9);
      taken_br = r == 0 || r == 3;
      is_jal = r == 1 || r == 3;
      is_jalr = r == 2 || r == 4;
      br_pc = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      imm = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      rs1_data = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFD : 32'hFFFF_FFFF);
      cyc();
      checks++; if (PC_out !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, PC_out, m_pc); end
      checks++; if (imem_req !== (m_mode == 1 && !stall)) begin failures++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, imem_req, m_mode == 1 && !stall); end
      checks++; if (misaligned !== (m_mode == 2)) begin failures++; $display("FAIL rnd_mis[%0d] got=%b exp=%b", i, misaligned, m_mode == 2); end
      checks++; if (mis_addr !== m_mis) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, mis_addr, m_mis); end
      checks++; if (pc_plus !== m_pc + 32'd4) begin failures++; $display("FAIL rnd_plus[%0d] got=%h exp=%h", i, pc_plus, m_pc + 32'd4); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_trap();
    test_stall_redirect();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
